// File: rtl/design05_initiator.sv
// design05_initiator: runs one command as start -> result -> check calls on a target,
// aborting any call whose RDY stays low for TIMEOUT cycles, then returns one response.
module design05_initiator #(
  parameter int WIDTH   = 9,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_c,
  input  logic [WIDTH-1:0] cmd_d,
  output logic [WIDTH-1:0] start_st_a,
  output logic [WIDTH-1:0] start_st_b,
  output logic             EN_start,
  input  logic             RDY_start,
  output logic [WIDTH-1:0] result_st_c,
  input  logic [WIDTH-1:0] result,
  input  logic             RDY_result,
  output logic [WIDTH-1:0] check_st_d,
  output logic             EN_check,
  input  logic [WIDTH-1:0] check,
  input  logic             RDY_check,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_check,
  output logic             rsp_timeout,
  output logic             busy
);
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  typedef enum logic [2:0] {IDLE, START, RESULT, CHECK, RESP} state_t;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d, rsp_check_q, rsp_check_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             wait_rdy, expired;
  // timer_q counts wait cycles already spent; the TIMEOUT-th one with RDY low aborts
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    rsp_result_d  = rsp_result_q;
    rsp_check_d   = rsp_check_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_rdy      = (state_q == START) ? RDY_start : (state_q == RESULT) ? RDY_result : RDY_check;
    expired       = timer_q == TW'(TIMEOUT - 1);
    case (state_q)
      IDLE: if (cmd_valid) begin
        a_d           = cmd_a;
        b_d           = cmd_b;
        c_d           = cmd_c;
        d_d           = cmd_d;
        rsp_result_d  = '0;
        rsp_check_d   = '0;
        rsp_timeout_d = 1'b0;
        timer_d       = '0;
        state_d       = START;
      end
      START, RESULT, CHECK: begin
        timer_d = (wait_rdy || expired) ? '0 : timer_q + TW'(1);
        if (wait_rdy) begin
          case (state_q)
            START:   state_d = RESULT;
            RESULT:  state_d = CHECK;
            default: state_d = RESP;
          endcase
          if (state_q == RESULT) rsp_result_d = result;
          if (state_q == CHECK) rsp_check_d = check;
        end else if (expired) begin
          state_d       = RESP;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: if (rsp_ready) begin
        state_d       = IDLE;
        rsp_timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      rsp_result_q  <= '0;
      rsp_check_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      rsp_result_q  <= rsp_result_d;
      rsp_check_q   <= rsp_check_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign cmd_ready   = (state_q == IDLE) && !RST;
  assign busy        = state_q != IDLE;
  assign EN_start    = (state_q == START) && RDY_start;
  assign EN_check    = (state_q == CHECK) && RDY_check;
  assign rsp_valid   = state_q == RESP;
  assign start_st_a  = a_q;
  assign start_st_b  = b_q;
  assign result_st_c = c_q;
  assign check_st_d  = d_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_check   = rsp_check_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: doc/design05_initiator.md
DESIGN05_INITIATOR -- requirements
Module: design05_initiator

Interface
REQ-001 Parameter WIDTH, default 9: width of every argument and result bus.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles waiting on any target RDY before abort.
REQ-003 Port CLK  in  1: single clock; all state updates on rising edge.
REQ-004 Port RST  in  1: reset, asynchronous and active-high.
REQ-005 Ports cmd_valid in 1, cmd_ready out 1: command handshake; transfer when both high on a CLK edge.
REQ-006 Ports cmd_a, cmd_b, cmd_c, cmd_d  in  WIDTH each: command operands.
REQ-007 Ports start_st_a, start_st_b  out  WIDTH: start-method arguments to target.
REQ-008 Ports EN_start out 1, RDY_start in 1: start-method enable and ready.
REQ-009 Ports result_st_c out WIDTH, result in WIDTH, RDY_result in 1: result value-method argument, return value, ready.
REQ-010 Ports check_st_d out WIDTH, EN_check out 1, check in WIDTH, RDY_check in 1: check action-value method.
REQ-011 Ports rsp_valid out 1, rsp_ready in 1: response handshake; transfer when both high on a CLK edge.
REQ-012 Ports rsp_result, rsp_check  out  WIDTH; rsp_timeout out 1: response payload.
REQ-013 Port busy out 1: high in every state except IDLE.

Function
REQ-014 States: IDLE, START, RESULT, CHECK, RESP; encoding free.
REQ-015 IDLE: cmd_ready=1; on cmd transfer latch a,b,c,d into registers, clear timer, go START.
REQ-016 cmd_ready SHALL be 0 in all states other than IDLE; no command queueing.
REQ-017 start_st_a/b, result_st_c, check_st_d SHALL be driven continuously from the latched registers.
REQ-018 START: EN_start = RDY_start (combinational, same cycle); when RDY_start=1 go RESULT next cycle, clear timer.
REQ-019 RESULT: when RDY_result=1 capture result into rsp_result register, go CHECK, clear timer.
REQ-020 CHECK: EN_check = RDY_check (combinational); when RDY_check=1 capture check into rsp_check register, go RESP.
REQ-021 EN_start and EN_check SHALL be 0 in every state other than START and CHECK respectively; each pulses exactly once per command.
REQ-022 Minimum latency: cmd transfer at edge N, with all RDY high, EN_start high in cycle N+1, result sampled edge N+2, EN_check high in cycle N+3, rsp_valid high from cycle N+4.
REQ-023 Timer: 8-bit-or-wider counter, increments each cycle in START/RESULT/CHECK while the awaited RDY is 0.
REQ-024 Timeout: when timer reaches TIMEOUT with awaited RDY still 0, go RESP with rsp_timeout=1; rsp_result/rsp_check not yet captured SHALL be 0.
REQ-025 RDY high in the same cycle the timer reaches TIMEOUT: RDY wins, no timeout.
REQ-026 RESP: rsp_valid=1, payload stable until rsp_ready=1; on transfer go IDLE, clear rsp_timeout.
REQ-027 rsp_ready=1 arriving in the first RESP cycle SHALL complete transfer that edge; next command accepted no earlier than following cycle.
REQ-028 rsp_result/rsp_check SHALL be cleared to 0 on each cmd transfer.

Reset
REQ-029 RST=1 SHALL immediately (asynchronously) force IDLE, timer 0, all latched operands 0, rsp payload 0.
REQ-030 During reset: cmd_ready=0, busy=0, EN_start=0, EN_check=0, rsp_valid=0, rsp_timeout=0, argument outputs 0.
REQ-031 Reset mid-operation SHALL abandon the command with no further EN pulses; cmd_ready=1 first cycle after RST falls.

Verification
REQ-032 All RDY=1, cmd a=0x1FF,b=0x001,c=0x0AA,d=0x155, target result=0x123, check=0x0F0 -> one EN_start, one EN_check, rsp_valid at N+4 with rsp_result=0x123, rsp_check=0x0F0, rsp_timeout=0.
REQ-033 RDY_start held 0 for 10 cycles then 1 -> EN_start only in cycle RDY rises; completes, rsp_timeout=0.
REQ-034 RDY_result never asserted, TIMEOUT=255 -> rsp_valid after 255 wait cycles, rsp_timeout=1, rsp_result=0, rsp_check=0, EN_check never pulsed.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and payload stable, cmd_ready=0 throughout; accept new command after transfer.
REQ-036 RST pulsed during CHECK wait -> outputs at reset values same cycle, no EN_check, next command completes normally.
REQ-037 RDY_check rises exactly on the TIMEOUT cycle -> EN_check pulses, rsp_timeout=0.
